// File: rtl/csa_resolve_pipe.sv
// Final carry-propagate adder for the multiplier datapath: it resolves the redundant
// sum/carry vectors in STAGES chunked ripple stages, using a valid/ready handshake on both sides.
module csa_resolve_pipe #(
    parameter int NN     = 32,
    parameter int STAGES = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [NN-1:0] in_sum,
    input  logic [NN-1:0] in_carry,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [NN-1:0] out_sum,
    output logic          out_cout,
    output logic          out_valid,
    input  logic          out_ready
);

    localparam int CW = NN / STAGES;

    logic [STAGES-1:0][NN-1:0] r_a;
    logic [STAGES-1:0][NN-1:0] r_b;
    logic [STAGES-1:0][NN-1:0] r_res;
    logic [STAGES-1:0]         r_cy;
    logic [STAGES-1:0]         r_vld;

    logic [STAGES-1:0][NN-1:0] w_a;
    logic [STAGES-1:0][NN-1:0] w_b;
    logic [STAGES-1:0][NN-1:0] w_res;
    logic [STAGES-1:0]         w_cy;
    logic [STAGES-1:0]         w_vld;
    logic                      w_adv;
    logic                      w_unused_skew;

    function automatic logic [CW:0] add_chunk(input logic [CW-1:0] a,
                                              input logic [CW-1:0] b,
                                              input logic          cin);
        return {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};
    endfunction

    // The pipeline advances as a whole; a held result freezes every stage behind it.
    assign w_adv    = !r_vld[STAGES-1] || out_ready;
    assign in_ready = w_adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [NN-1:0] w_res_in;
        logic [NN-1:0] w_res_nxt;
        logic          w_cin;
        logic [CW:0]   w_chunk;

        if (k == 0) begin : g_first
            assign w_a[k]   = in_sum;
            assign w_b[k]   = in_carry;
            assign w_vld[k] = in_valid;
            assign w_cin    = 1'b0;
            assign w_res_in = '0;
        end else begin : g_next
            assign w_a[k]   = r_a[k-1];
            assign w_b[k]   = r_b[k-1];
            assign w_vld[k] = r_vld[k-1];
            assign w_cin    = r_cy[k-1];
            assign w_res_in = r_res[k-1];
        end

        assign w_chunk = add_chunk(w_a[k][k*CW +: CW], w_b[k][k*CW +: CW], w_cin);

        always_comb begin
            w_res_nxt               = w_res_in;
            w_res_nxt[k*CW +: CW]   = w_chunk[CW-1:0];
        end

        assign w_res[k] = w_res_nxt;
        assign w_cy[k]  = w_chunk[CW];
    end

    // ---- stage registers: each stage k captures stage k-1 (stage 0 captures the inputs)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
            r_cy  <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_res <= '0;
        end else if (w_adv) begin
            r_vld <= w_vld;
            r_cy  <= w_cy;
            r_a   <= w_a;
            r_b   <= w_b;
            r_res <= w_res;
        end
    end

    // The last stage's operand skew has already been consumed by its own adder.
    assign w_unused_skew = ^{r_a[STAGES-1], r_b[STAGES-1]};

    assign out_sum   = r_res[STAGES-1];
    assign out_cout  = r_cy[STAGES-1];
    assign out_valid = r_vld[STAGES-1];

endmodule

// File: doc/csa_resolve_pipe.md
Name: csa_resolve_pipe

Overview:
- Final carry-propagate stage of the DSP multiplier datapath.
- Sits directly downstream of the 3:2/4:2 carry-save compressor tree and consumes its two redundant outputs (sum vector, carry vector).
- Resolves the two vectors into one binary word using a pipelined chunked adder: STAGES ripple chunks, with a registered carry between chunks.
- Uses a valid/ready handshake on both sides so the compressor tree can be stalled by downstream consumers.

Parameters:
- NN, 32, operand/result width; must be an integer multiple of STAGES.
- STAGES, 4, number of pipeline stages (adder chunks); chunk width CW = NN/STAGES; legal range 1..NN.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_sum  input  NN  sum vector from the compressor tree.
- in_carry  input  NN  carry vector from the compressor tree, already left-aligned (bit 0 is normally 0; it is added as-is).
- in_valid  input  1  in_sum/in_carry hold a valid operand pair.
- in_ready  output  1  block accepts the operand pair this cycle.
- out_sum  output  NN  (in_sum + in_carry) mod 2^NN.
- out_cout  output  1  bit NN of the full sum.
- out_valid  output  1  out_sum/out_cout are valid.
- out_ready  input  1  downstream accepts the result.

Behaviour:
- Reset (async, rst=1): every stage valid bit clears to 0.
  - out_valid=0, out_sum=0, out_cout=0.
  - All data/skew registers clear to 0.
  - in_ready=1 combinationally once rst deasserts.
- Global advance: adv = !out_valid | out_ready.
  - in_ready = adv (combinational; no dependence on in_valid).
  - A transfer is accepted when in_valid & in_ready.
- When adv=1, on every clock edge each stage k loads stage k-1 contents, including its valid bit. Stage 0 loads the input and in_valid.
- When adv=0, all stage registers (data, carries, valid bits) hold.
- Stage k (0..STAGES-1): adds bits [k*CW +: CW] of sum and carry plus the carry-in registered by stage k-1.
  - Stage 0 has carry-in 0.
  - It registers the CW-bit result chunk and its carry-out.
- Skew: operand chunks not yet consumed travel alongside in delay registers. Resolved low chunks travel forward in delay registers so the full word emerges aligned.
- The last stage drives out_sum (all chunks) and out_cout (carry-out of chunk STAGES-1). out_valid is the last stage's valid bit.
- Latency: exactly STAGES cycles from the accept edge to out_valid=1 when unstalled. Throughput is 1 result/cycle.
- Bubbles (in_valid=0 while adv=1) propagate as valid=0 stages. Data registers of bubble stages may update, but out_sum/out_cout only matter while out_valid=1.
- While out_valid=1 and out_ready=0: out_sum, out_cout and out_valid are held stable; in_ready=0.
- Ordering: results emerge strictly in acceptance order, with no loss and no duplication under any stall pattern.
- Simultaneous out_ready=1 and new input accepted: the result leaves, the pipeline shifts by one, and the new operand enters stage 0 on the same edge.
- Reset mid-operation: all in-flight results are discarded immediately (out_valid drops asynchronously). The first post-reset output requires a new accept.
- Arithmetic: the result equals the full (NN+1)-bit sum of the two NN-bit unsigned vectors. Signed interpretation is the consumer's concern (drop out_cout).
- STAGES=1: a single registered NN-bit adder with the same handshake and latency 1.

Test Plan:
- NN=32, STAGES=4; in_sum=0x12345678, in_carry=0x11111111, out_ready=1 -> 4 cycles later out_valid=1, out_sum=0x23456789, out_cout=0.
- Full carry ripple: 0xFFFFFFFF + 0x00000001 -> out_sum=0x00000000, out_cout=1; then 0x00FFFFFF + 0x00000001 -> 0x01000000, cout=0. Checks the carry crossing all chunk boundaries.
- Stream of 6 back-to-back pairs (i, 3*i, i=1..6), out_ready=0 on cycles 6-8:
  - in_ready=0 during the stall.
  - Outputs held stable during the stall.
  - Results 4,8,12,16,20,24 delivered in order with no drops or duplicates.
- Alternating in_valid 1/0 with random out_ready -> the scoreboard matches every accepted pair to exactly one result, in order.
- rst pulsed asynchronously mid-clock with 3 results in flight -> out_valid=0 immediately and no stale result appears afterwards. After rst falls, a new pair 0x5+0xA yields 0xF after 4 cycles.
- Rerun the first two scenarios with STAGES=1 (latency 1) and STAGES=8 (latency 8) -> identical result values.
